// File: rtl/angle_telemetry_tx.sv
// UART telemetry transmitter: frames a 12-byte packet (header, FSM state, three
// 24-bit joint angles, mod-256 checksum) as back-to-back 8N1 characters.
module angle_telemetry_tx #(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        send,
  input  logic [23:0] shoulder_angle,
  input  logic [23:0] elbow_angle,
  input  logic [23:0] base_angle,
  input  logic [2:0]  state,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} fsm_t;

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  fsm_t        fsm;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [3:0]  byte_idx;
  logic [7:0]  shreg;
  logic [2:0]  state_q;
  logic [23:0] shoulder_q;
  logic [23:0] elbow_q;
  logic [23:0] base_q;
  logic [7:0]  checksum;
  logic [7:0]  cur_byte;
  logic        bit_end;

  assign bit_end = (bit_cnt == BIT_LAST);

  always_comb begin
    checksum = {5'b0, state_q}
             + shoulder_q[23:16] + shoulder_q[15:8] + shoulder_q[7:0]
             + elbow_q[23:16]    + elbow_q[15:8]    + elbow_q[7:0]
             + base_q[23:16]     + base_q[15:8]     + base_q[7:0];
  end

  // Byte 0 is a constant, so the snapshot registers only need to be valid
  // by the time byte 1 is first selected.
  always_comb begin
    cur_byte = HEADER;
    case (byte_idx)
      4'd1:    cur_byte = {5'b0, state_q};
      4'd2:    cur_byte = shoulder_q[23:16];
      4'd3:    cur_byte = shoulder_q[15:8];
      4'd4:    cur_byte = shoulder_q[7:0];
      4'd5:    cur_byte = elbow_q[23:16];
      4'd6:    cur_byte = elbow_q[15:8];
      4'd7:    cur_byte = elbow_q[7:0];
      4'd8:    cur_byte = base_q[23:16];
      4'd9:    cur_byte = base_q[15:8];
      4'd10:   cur_byte = base_q[7:0];
      4'd11:   cur_byte = checksum;
      default: cur_byte = HEADER;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm        <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      shreg      <= '0;
      state_q    <= '0;
      shoulder_q <= '0;
      elbow_q    <= '0;
      base_q     <= '0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          bit_cnt <= '0;
          if (send) begin
            fsm        <= START;
            tx         <= 1'b0;
            busy       <= 1'b1;
            byte_idx   <= '0;
            bit_idx    <= '0;
            state_q    <= state;
            shoulder_q <= shoulder_angle;
            elbow_q    <= elbow_angle;
            base_q     <= base_angle;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            fsm     <= DATA;
            tx      <= cur_byte[0];
            shreg   <= {1'b0, cur_byte[7:1]};
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              fsm <= STOP;
              tx  <= 1'b1;
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (byte_idx == 4'd11) begin
              fsm  <= IDLE;
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              fsm      <= START;
              tx       <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_angle_telemetry_tx.sv
// Directed bench for angle_telemetry_tx: records tx per cycle, decodes the
// 12 UART bytes and compares them against hand-computed packet contents.
module tb_angle_telemetry_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        send;
  logic [23:0] shoulder_angle;
  logic [23:0] elbow_angle;
  logic [23:0] base_angle;
  logic [2:0]  state;
  logic        tx;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int done_count = 0;
  int done_cycle[$];
  logic rec [0:480];

  angle_telemetry_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
    .clk(clk),
    .reset(reset),
    .send(send),
    .shoulder_angle(shoulder_angle),
    .elbow_angle(elbow_angle),
    .base_angle(base_angle),
    .state(state),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_count++;
      done_cycle.push_back(cycle);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives the packet fields and raises send so it is seen on the next edge.
  task automatic applyStimulus(input logic [2:0] st, input logic [23:0] sh,
                               input logic [23:0] el, input logic [23:0] ba);
    @(negedge clk);
    state          = st;
    shoulder_angle = sh;
    elbow_angle    = el;
    base_angle     = ba;
    send           = 1'b1;
    @(posedge clk);
  endtask

  // Called right after the acceptance edge; sample i is the tx level after edge k+i.
  task automatic capturePacket(input string tag, input logic [95:0] exp_bytes,
                               input int release_at, input bit glitch);
    int frame_err = 0;
    int seg_err = 0;
    int busy_err = 0;
    logic end_busy;
    logic end_done;
    logic [7:0] got;
    end_busy = 1'bx;
    end_done = 1'bx;
    for (int i = 0; i <= 480; i++) begin
      @(negedge clk);
      rec[i] = tx;
      if (i < 480 && busy !== 1'b1) busy_err++;
      if (i == 480) begin
        end_busy = busy;
        end_done = done;
      end
      if (i == release_at) send = 1'b0;
      if (glitch && i == 100) begin
        shoulder_angle = 24'hFFFFFF;
        send = 1'b1;
      end
      if (glitch && i == 101) send = 1'b0;
    end
    for (int n = 0; n < 120; n++)
      for (int k = 1; k < CPB; k++)
        if (rec[n*CPB+k] !== rec[n*CPB]) seg_err++;
    for (int b = 0; b < 12; b++) begin
      if (rec[b*40] !== 1'b0) frame_err++;
      if (rec[b*40+36] !== 1'b1) frame_err++;
      for (int j = 0; j < 8; j++) got[j] = rec[b*40 + 4 + 4*j + 2];
      checkOutput($sformatf("%s byte%0d", tag, b), got, exp_bytes[95-8*b -: 8]);
    end
    checkOutput({tag, " framing errors"}, frame_err, 0);
    checkOutput({tag, " bit segment errors"}, seg_err, 0);
    checkOutput({tag, " busy low during packet"}, busy_err, 0);
    checkOutput({tag, " tx idle after packet"}, rec[480], 1'b1);
    checkOutput({tag, " busy after packet"}, end_busy, 1'b0);
    checkOutput({tag, " done at end"}, end_done, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_seen;
    int bad;
    int dc;
    reset = 1'b0;
    send = 1'b0;
    state = '0;
    shoulder_angle = '0;
    elbow_angle = '0;
    base_angle = '0;

    #12;
    checkOutput("reset tx", tx, 1'b1);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle busy after reset", busy, 1'b0);

    $display("[TB] basic packet");
    applyStimulus(3'd3, 24'h0186A0, 24'h030D40, 24'h0249F0);
    capturePacket("basic", 96'hA5_03_01_86_A0_03_0D_40_02_49_F0_B5, 0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("basic done pulses", done_count, 1);

    $display("[TB] snapshot and ignored send");
    applyStimulus(3'd3, 24'h0186A0, 24'h030D40, 24'h0249F0);
    capturePacket("snapshot", 96'hA5_03_01_86_A0_03_0D_40_02_49_F0_B5, 0, 1'b1);
    busy_seen = 0;
    repeat (600) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
    end
    checkOutput("no queued packet", busy_seen, 0);
    checkOutput("snapshot done pulses", done_count, 2);

    $display("[TB] back-to-back packets");
    applyStimulus(3'd3, 24'h0186A0, 24'h030D40, 24'h0249F0);
    capturePacket("b2b first", 96'hA5_03_01_86_A0_03_0D_40_02_49_F0_B5, -1, 1'b0);
    capturePacket("b2b second", 96'hA5_03_01_86_A0_03_0D_40_02_49_F0_B5, 100, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("b2b done pulses", done_count, 4);
    if (done_cycle.size() >= 4)
      checkOutput("b2b done spacing", done_cycle[3] - done_cycle[2], 481);
    else
      checkOutput("b2b done spacing", 0, 481);

    $display("[TB] mid-packet reset");
    applyStimulus(3'd1, 24'h123456, 24'h654321, 24'h0F0F0F);
    @(negedge clk);
    send = 1'b0;
    repeat (49) @(negedge clk);
    dc = done_count;
    checkOutput("busy before abort", busy, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("abort tx async", tx, 1'b1);
    checkOutput("abort busy async", busy, 1'b0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checkOutput("reset window outputs", bad, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("no done after abort", done_count, dc);
    checkOutput("idle after abort", busy, 1'b0);

    $display("[TB] checksum wrap");
    applyStimulus(3'd7, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    capturePacket("wrap", 96'hA5_07_FF_FF_FF_FF_FF_FF_FF_FF_FF_FE, 0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("wrap done pulses", done_count, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
